fwdkm_seq: RTL and testbench
============================

Name: fwdkm_seq

Overview:
Sequential, parametrised forward-kinematics engine for a yaw base plus an NJ-link planar pitch chain. It produces the end-effector x/y/z position in fixed point. It accepts one joint-angle vector per valid/ready transaction and time-shares one external cosine unit through a request/response port. Its results feed the trajectory checker and inverse-kinematics iteration loop.

Parameters:
NJ, 3, number of pitch links in the chain
ANG_W, 32, angle width; full turn = 2^ANG_W, arithmetic modulo 2^ANG_W
COS_W, 32, signed cosine width; F = COS_W-2 fraction bits (1.0 = 2^F)
LEN_W, 16, unsigned link-length / base-height width
ACC_W, 64, signed accumulator and output width

Ports:
clk  in  1  clock, rising edge
reset  in  1  reset, asynchronous, active-high
in_valid  in  1  request valid
in_ready  out  1  high only in IDLE
yaw_ang  in  ANG_W  base yaw joint angle
jnt_ang  in  NJ*ANG_W  pitch joint angles; link k at bits [k*ANG_W +: ANG_W]
jnt_off  in  NJ*ANG_W  per-link zero offsets
link_len  in  NJ*LEN_W  link lengths
base_h  in  LEN_W  base height
cos_req_valid  out  1  cosine request
cos_req_ready  in  1  cosine unit accepts request
cos_req_angle  out  ANG_W  angle to evaluate
cos_rsp_valid  in  1  cosine result valid
cos_rsp_data  in  COS_W  signed cos, scale 2^F
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
pos_x, pos_y, pos_z  out  ACC_W  signed position, length units * 2^F
busy  out  1  state != IDLE

Behaviour:
- Reset (async): state=IDLE; out_valid=0; cos_req_valid=0; pos_*=0; accumulators=0; busy=0.
- Accept on in_valid&in_ready: register all inputs and clear r, h.
- Angle rule: theta_k = sum over i<=k of (jnt_off_i + jnt_ang_i), mod 2^ANG_W. Q = 2^(ANG_W-2) (quarter turn). sin(a) is obtained as cos(a-Q).
- Op sequence, 2*NJ+2 ops:
  - For k=1..NJ: cos(theta_k), then cos(theta_k - Q).
  - Then cos(yaw), then cos(yaw - Q).
- States: IDLE -> REQ -> WAIT -> (REQ for next op | DONE) -> IDLE.
  - REQ: cos_req_valid=1 with stable cos_req_angle until cos_req_ready; then go to WAIT.
  - WAIT: on cos_rsp_valid, consume the data and advance the op index.
  - cos_rsp_valid outside WAIT is ignored. At most one request is outstanding.
- Per-response arithmetic. Each product is zero-extended L_k times sign-extended cos, widened to ACC_W:
  - link cos: r += L_k*c
  - link sin: h += L_k*c
  - yaw cos: pos_z <= (r*c)>>>F
  - yaw sin: pos_x <= (r*c)>>>F, pos_y <= (base_h<<F) + h, out_valid <= 1, state <= DONE
- >>> is arithmetic shift (floor). No saturation; wrap at ACC_W.
- DONE: outputs held stable while out_valid=1 and !out_ready. On out_ready, go to IDLE and drop out_valid. This gives a one-cycle bubble before the next accept.
- Latency with cos_req_ready=1 and response one cycle after acceptance:
  - Accept at edge E; out_valid rises after edge E+4*NJ+4 (E+16 for NJ=3).
  - Each stall cycle on the request or response adds exactly one cycle.
- Reset mid-operation aborts the transaction immediately. A late cos_rsp_valid after reset is ignored (state is IDLE).
- in_ready=0 whenever busy, so in_valid is ignored in every non-IDLE state.

Test Plan:
All tests use NJ=3, links 524/1064/1687, base 290, F=30, and an ideal cosine model with one-cycle response.
- Zero test: all angles and offsets 0 -> pos_z=3275*2^30, pos_x=0, pos_y=290*2^30; out_valid rises exactly 16 edges after accept.
- Yaw test: yaw=0x4000_0000, rest 0 -> pos_x=3275*2^30, pos_z=0, pos_y=290*2^30.
- Chain pitch test: jnt_ang link1=0x4000_0000, rest 0 -> all theta=Q; pos_x=pos_z=0; pos_y=3565*2^30.
- Wrap test: off1=0xC000_0000, jnt1=0x4000_0000 -> results identical to the zero test.
- Backpressure test: cos_req_ready low 5 cycles on op 3 and out_ready low 4 cycles -> latency 21; cos_req_angle and pos_* stable while stalled; in_ready stays 0.
- Reset test: assert reset during op 4, then pulse cos_rsp_valid -> outputs 0, state IDLE, in_ready=1; the next transaction gives the zero-test result.

Source files
------------

// File: rtl/fwdkm_seq.sv
// Sequential forward kinematics for a yaw base plus an NJ-link planar pitch chain.
// One external cosine unit is time-shared; every sine is evaluated as cos(a - quarter turn).
module fwdkm_seq #(
  parameter int unsigned NJ    = 3,
  parameter int unsigned ANG_W = 32,
  parameter int unsigned COS_W = 32,
  parameter int unsigned LEN_W = 16,
  parameter int unsigned ACC_W = 64
) (
  input  logic                 clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ANG_W-1:0]    yaw_ang,
  input  logic [NJ*ANG_W-1:0] jnt_ang,
  input  logic [NJ*ANG_W-1:0] jnt_off,
  input  logic [NJ*LEN_W-1:0] link_len,
  input  logic [LEN_W-1:0]    base_h,
  output logic                cos_req_valid,
  input  logic                cos_req_ready,
  output logic [ANG_W-1:0]    cos_req_angle,
  input  logic                cos_rsp_valid,
  input  logic [COS_W-1:0]    cos_rsp_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    pos_x,
  output logic [ACC_W-1:0]    pos_y,
  output logic [ACC_W-1:0]    pos_z,
  output logic                busy
);

  localparam int unsigned F    = COS_W - 2;
  localparam int unsigned NOPS = 2 * NJ + 2;
  localparam int unsigned OP_W = $clog2(NOPS);
  localparam logic [ANG_W-1:0] QTR = ANG_W'(1) << (ANG_W - 2);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e                state_q, state_d;
  logic [OP_W-1:0]       op_q, op_d;
  logic [ANG_W-1:0]      yaw_q;
  logic [NJ*ANG_W-1:0]   ang_q, off_q;
  logic [NJ*LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]      base_q;
  logic [ACC_W-1:0]      r_q, r_d, h_q, h_d;
  logic [ACC_W-1:0]      pos_x_q, pos_x_d, pos_y_q, pos_y_d, pos_z_q, pos_z_d;
  logic                  out_valid_q, out_valid_d;
  logic                  capture;

  logic [ANG_W-1:0]      theta [NJ];
  logic [ANG_W-1:0]      op_ang;
  logic [LEN_W-1:0]      op_len;
  logic                  is_yaw;
  logic [ACC_W-1:0]      c_ext, l_ext, lin_prod, base_term, yaw_res;
  logic [ACC_W+F-1:0]    r_wide, c_wide;

  // Absolute link angles are prefix sums of (offset + joint), wrapping mod 2^ANG_W.
  always_comb begin : theta_gen
    logic [ANG_W-1:0] sum;
    sum = '0;
    for (int unsigned k = 0; k < NJ; k++) begin
      sum      = sum + off_q[k*ANG_W +: ANG_W] + ang_q[k*ANG_W +: ANG_W];
      theta[k] = sum;
    end
  end

  // Ops 2k / 2k+1 are cos / sin of link k; the last pair targets the yaw angle.
  assign is_yaw = (op_q >= OP_W'(2 * NJ));

  always_comb begin
    op_ang = yaw_q;
    op_len = '0;
    for (int unsigned k = 0; k < NJ; k++) begin
      if (32'(op_q >> 1) == k) begin
        op_ang = theta[k];
        op_len = len_q[k*LEN_W +: LEN_W];
      end
    end
  end

  assign cos_req_angle = op_ang - (op_q[0] ? QTR : '0);

  assign c_ext     = {{(ACC_W-COS_W){cos_rsp_data[COS_W-1]}}, cos_rsp_data};
  assign l_ext     = {{(ACC_W-LEN_W){1'b0}}, op_len};
  assign lin_prod  = l_ext * c_ext;
  assign base_term = {{(ACC_W-LEN_W){1'b0}}, base_q} << F;

  // Only product bits [F +: ACC_W] survive the shift, so ACC_W+F bits of width suffice.
  assign r_wide  = {{F{r_q[ACC_W-1]}}, r_q};
  assign c_wide  = {{F{c_ext[ACC_W-1]}}, c_ext};
  assign yaw_res = ACC_W'((r_wide * c_wide) >> F);

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    r_d           = r_q;
    h_d           = h_q;
    pos_x_d       = pos_x_q;
    pos_y_d       = pos_y_q;
    pos_z_d       = pos_z_q;
    out_valid_d   = out_valid_q;
    capture       = 1'b0;
    in_ready      = 1'b0;
    cos_req_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          capture = 1'b1;
          op_d    = '0;
          r_d     = '0;
          h_d     = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        cos_req_valid = 1'b1;
        if (cos_req_ready) state_d = StWait;
      end
      StWait: begin
        if (cos_rsp_valid) begin
          op_d    = op_q + 1'b1;
          state_d = StReq;
          if (!is_yaw) begin
            if (op_q[0]) h_d = h_q + lin_prod;
            else         r_d = r_q + lin_prod;
          end else if (!op_q[0]) begin
            pos_z_d = yaw_res;
          end else begin
            pos_x_d     = yaw_res;
            pos_y_d     = base_term + h_q;
            out_valid_d = 1'b1;
            state_d     = StDone;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      op_q        <= '0;
      r_q         <= '0;
      h_q         <= '0;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      pos_z_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      r_q         <= r_d;
      h_q         <= h_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      pos_z_q     <= pos_z_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      yaw_q  <= '0;
      ang_q  <= '0;
      off_q  <= '0;
      len_q  <= '0;
      base_q <= '0;
    end else if (capture) begin
      yaw_q  <= yaw_ang;
      ang_q  <= jnt_ang;
      off_q  <= jnt_off;
      len_q  <= link_len;
      base_q <= base_h;
    end
  end

  assign out_valid = out_valid_q;
  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;
  assign pos_z     = pos_z_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_fwdkm_seq.sv
// Bench for fwdkm_seq: ideal cosine unit, closed-form kinematics model and per-cycle compare.
module tb_fwdkm_seq;

  localparam int NJ = 3;
  localparam logic [31:0] QTR  = 32'h4000_0000;
  localparam logic [47:0] LENS = {16'd1687, 16'd1064, 16'd524};
  localparam logic [15:0] BASE = 16'd290;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] yaw_ang;
  logic [95:0] jnt_ang, jnt_off;
  logic [47:0] link_len;
  logic [15:0] base_h;
  logic        cos_req_valid, cos_req_ready;
  logic [31:0] cos_req_angle;
  logic        cos_rsp_valid;
  logic [31:0] cos_rsp_data;
  logic        out_valid, out_ready;
  logic [63:0] pos_x, pos_y, pos_z;
  logic        busy;

  fwdkm_seq #(.NJ(3), .ANG_W(32), .COS_W(32), .LEN_W(16), .ACC_W(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .yaw_ang(yaw_ang), .jnt_ang(jnt_ang), .jnt_off(jnt_off), .link_len(link_len),
    .base_h(base_h), .cos_req_valid(cos_req_valid), .cos_req_ready(cos_req_ready),
    .cos_req_angle(cos_req_angle), .cos_rsp_valid(cos_rsp_valid),
    .cos_rsp_data(cos_rsp_data), .out_valid(out_valid), .out_ready(out_ready),
    .pos_x(pos_x), .pos_y(pos_y), .pos_z(pos_z), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_x = '0, exp_y = '0, exp_z = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, $signed(act), $signed(req));
    end
  endtask

  // Ideal cosine, scale 2^30, rounded to nearest.
  function automatic logic signed [31:0] cosf(input logic [31:0] a);
    real ar, v;
    ar = a;
    v  = $cos(2.0 * 3.14159265358979323846 * ar / 4294967296.0) * 1073741824.0;
    if (v >= 0.0) return 32'($rtoi(v + 0.5));
    else          return -32'($rtoi(-v + 0.5));
  endfunction

  // Closed-form chain: r = sum L cos(theta), h = sum L sin(theta), then yaw rotation.
  function automatic void model(input logic [31:0] y, input logic [95:0] a, input logic [95:0] o,
                                input logic [47:0] l, input logic [15:0] b,
                                output logic [63:0] x, output logic [63:0] yy,
                                output logic [63:0] z);
    logic [31:0]         th;
    longint              r, h, len;
    logic signed [127:0] p;
    th = '0; r = 0; h = 0;
    for (int k = 0; k < NJ; k++) begin
      th  = th + o[k*32 +: 32] + a[k*32 +: 32];
      len = longint'(l[k*16 +: 16]);
      r   = r + len * longint'(cosf(th));
      h   = h + len * longint'(cosf(th - QTR));
    end
    p  = 128'(r) * 128'(cosf(y));
    z  = p[93:30];
    p  = 128'(r) * 128'(cosf(y - QTR));
    x  = p[93:30];
    yy = (longint'(b) << 30) + h;
  endfunction

  // Cosine unit: accepts requests, answers after 0..2 extra cycles in random mode.
  int          op_cnt = 0;
  int          stall_op = -1;
  int          stall_left = 0;
  bit          rand_mode = 0;
  bit          cos_manual = 0;
  bit          pend = 0;
  int          pend_dly = 0;
  logic [31:0] pend_data = '0;
  logic [31:0] last_ang = '0;
  bit          last_stalled = 0;

  initial begin
    cos_req_ready = 1'b0;
    cos_rsp_valid = 1'b0;
    cos_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (cos_manual) begin
        pend = 0;
        last_stalled = 0;
        continue;
      end
      if (last_stalled && cos_req_valid)
        check("cos_req_angle_stable", cos_req_angle, last_ang);
      cos_rsp_valid = 1'b0;
      if (pend) begin
        if (pend_dly == 0) begin
          cos_rsp_valid = 1'b1;
          cos_rsp_data  = pend_data;
          pend = 0;
        end else begin
          pend_dly--;
        end
      end
      if (cos_req_valid && op_cnt == stall_op && stall_left > 0) begin
        cos_req_ready = 1'b0;
        stall_left--;
      end else if (rand_mode) begin
        cos_req_ready = ($urandom_range(0, 2) != 0);
      end else begin
        cos_req_ready = 1'b1;
      end
      last_stalled = cos_req_valid && !cos_req_ready;
      last_ang     = cos_req_angle;
      if (cos_req_valid && cos_req_ready) begin
        pend      = 1;
        pend_dly  = rand_mode ? int'($urandom_range(0, 2)) : 0;
        pend_data = cosf(cos_req_angle);
        op_cnt++;
      end
    end
  end

  // Compare process: handshake consistency every cycle, positions whenever out_valid.
  always @(negedge clk) begin
    if (!reset) begin
      check("in_ready_vs_busy", 64'(in_ready), 64'(!busy));
      if (out_valid) begin
        check("pos_x", pos_x, exp_x);
        check("pos_y", pos_y, exp_y);
        check("pos_z", pos_z, exp_z);
      end
    end
  end

  task automatic start_txn(input logic [31:0] y, input logic [95:0] a, input logic [95:0] o,
                           input logic [47:0] l, input logic [15:0] b);
    int guard = 0;
    yaw_ang = y; jnt_ang = a; jnt_off = o; link_len = l; base_h = b;
    in_valid = 1'b1;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    model(y, a, o, l, b, exp_x, exp_y, exp_z);
    op_cnt = 0;
    @(negedge clk);
    in_valid = 1'b0;
    // Inputs change after accept; the DUT must be working from its registered copy.
    yaw_ang  = $urandom;
    jnt_ang  = {$urandom, $urandom, $urandom};
    jnt_off  = {$urandom, $urandom, $urandom};
    link_len = {16'($urandom), 16'($urandom), 16'($urandom)};
    base_h   = 16'($urandom);
  endtask

  task automatic finish_txn(input int exp_lat, input int ostall);
    int edges = 0;
    out_ready = 1'b0;
    while (!out_valid && edges < 400) begin
      @(negedge clk);
      edges++;
    end
    if (!out_valid) begin
      check("result_timeout", 64'(out_valid), 64'd1);
      return;
    end
    if (exp_lat >= 0) check("latency", 64'(edges), 64'(exp_lat));
    repeat (ostall) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drop", 64'(out_valid), 64'd0);
    check("in_ready_after_done", 64'(in_ready), 64'd1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    yaw_ang = '0; jnt_ang = '0; jnt_off = '0; link_len = LENS; base_h = BASE;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_req_valid", 64'(cos_req_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_pos_x", pos_x, 64'd0);
    check("rst_pos_y", pos_y, 64'd0);
    check("rst_pos_z", pos_z, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Zero pose: arm straight along the z reach axis.
    start_txn(32'd0, 96'd0, 96'd0, LENS, BASE);
    check("model_zero_z", exp_z, longint'(3275) << 30);
    check("model_zero_x", exp_x, 64'd0);
    check("model_zero_y", exp_y, longint'(290) << 30);
    finish_txn(16, 0);

    start_txn(QTR, 96'd0, 96'd0, LENS, BASE);
    check("model_yaw_x", exp_x, longint'(3275) << 30);
    check("model_yaw_z", exp_z, 64'd0);
    finish_txn(16, 1);

    start_txn(32'd0, {64'd0, QTR}, 96'd0, LENS, BASE);
    check("model_pitch_y", exp_y, longint'(3565) << 30);
    check("model_pitch_x", exp_x, 64'd0);
    finish_txn(16, 0);

    start_txn(32'd0, {64'd0, QTR}, {64'd0, 32'hC000_0000}, LENS, BASE);
    check("model_wrap_z", exp_z, longint'(3275) << 30);
    finish_txn(16, 2);

    // Request stall on op 3 plus output backpressure.
    stall_op = 3; stall_left = 5;
    start_txn(32'h1234_5678, {$urandom, $urandom, $urandom}, 96'd0, LENS, BASE);
    finish_txn(21, 4);
    stall_op = -1;

    // Abort mid-transaction, then a stray response while idle.
    start_txn(32'd0, 96'd0, 96'd0, LENS, BASE);
    begin
      int guard = 0;
      while (op_cnt < 5 && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      check("reach_op4", 64'(op_cnt >= 5), 64'd1);
    end
    #1;
    cos_manual = 1; reset = 1'b1; cos_rsp_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0; cos_rsp_valid = 1'b1; cos_rsp_data = 32'h4000_0000;
    @(negedge clk);
    cos_rsp_valid = 1'b0;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_req_valid", 64'(cos_req_valid), 64'd0);
    check("abort_pos_x", pos_x, 64'd0);
    check("abort_pos_y", pos_y, 64'd0);
    check("abort_pos_z", pos_z, 64'd0);
    cos_manual = 0;
    start_txn(32'd0, 96'd0, 96'd0, LENS, BASE);
    finish_txn(16, 0);

    for (int t = 0; t < 24; t++) begin
      logic [47:0] l;
      rand_mode = (t % 2 == 1);
      l = (t % 3 == 0) ? {16'($urandom), 16'($urandom), 16'($urandom)} : LENS;
      start_txn($urandom, {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom},
                l, 16'($urandom));
      finish_txn(rand_mode ? -1 : 16, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
